// File: rtl/hci_package.sv
// Shared HCI control types and responder FSM encodings.
package hci_package;

    typedef struct packed {
        logic [1:0] arb_policy;
        logic       invert_prio;
        logic [7:0] low_prio_max_stall;
    } hci_interconnect_ctrl_t;

    typedef struct packed {
        logic       stall_en;
        logic [7:0] stall_cycles;
    } hci_responder_ctrl_t;

    localparam logic [0:0] RSP_READY = 1'b0;
    localparam logic [0:0] RSP_STALL = 1'b1;

endpackage

// File: rtl/hci_mem_intf.sv
// Memory-side HCI endpoint: request channel plus registered response channel.
interface hci_mem_intf #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32,
    parameter int unsigned IW = 8,
    parameter int unsigned UW = 1
);
    logic            req;
    logic            gnt;
    logic [AW-1:0]   add;
    logic            wen;
    logic [DW/8-1:0] be;
    logic [DW-1:0]   data;
    logic [IW-1:0]   id;
    logic [UW-1:0]   user;
    logic [DW-1:0]   r_data;
    logic [IW-1:0]   r_id;
    logic [UW-1:0]   r_user;

    modport master (output req, add, wen, be, data, id, user,
                    input  gnt, r_data, r_id, r_user);
    modport slave  (input  req, add, wen, be, data, id, user,
                    output gnt, r_data, r_id, r_user);
endinterface

// File: rtl/hci_mem_responder_storage.sv
// Word storage with per-byte write enables and a registered, held read port.
module hci_mem_responder_storage #(
    parameter int unsigned DW       = 32,
    parameter int unsigned NB_WORDS = 1024,
    parameter int unsigned IDXW     = $clog2(NB_WORDS)
) (
    input  logic            i_clk,
    input  logic            i_clr,
    input  logic            i_we,
    input  logic            i_re,
    input  logic            i_rzero,
    input  logic [IDXW-1:0] i_idx,
    input  logic [DW/8-1:0] i_be,
    input  logic [DW-1:0]   i_wdata,
    output logic [DW-1:0]   o_rdata
);
    logic [DW-1:0] r_mem [NB_WORDS];
    logic [DW-1:0] r_rdata;

    // Storage has no reset: contents survive both reset and soft clear.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < DW/8; b++) begin
                if (i_be[b]) r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clr)     r_rdata <= '0;
        else if (i_re) r_rdata <= i_rzero ? '0 : r_mem[i_idx];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/hci_mem_responder.sv
// TCDM responder: single-cycle memory with optional post-grant stall window.
module hci_mem_responder
    import hci_package::*;
#(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 32,
    parameter int unsigned IW       = 8,
    parameter int unsigned UW       = 1,
    parameter int unsigned NB_WORDS = 1024
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  hci_responder_ctrl_t ctrl_i,
    hci_mem_intf.slave          tcdm,
    output logic                err_o
);
    localparam int unsigned OFFW = $clog2(DW/8);
    localparam int unsigned IDXW = $clog2(NB_WORDS);

    logic [0:0]    r_state;
    logic [7:0]    r_cnt;
    logic [IW-1:0] r_id;
    logic [UW-1:0] r_user;
    logic          r_err;

    logic [AW-1:0]   w_add;
    logic [IDXW-1:0] w_idx;
    logic            w_in_range;
    logic            w_gnt;
    logic            w_clr;
    logic [DW-1:0]   w_rdata;
    logic            w_unused;

    assign w_add      = tcdm.add;
    assign w_idx      = w_add[IDXW+OFFW-1:OFFW];
    assign w_unused   = ^{w_add[AW-1:IDXW+OFFW], w_add[OFFW-1:0]};
    // Only reachable with a non-power-of-2 depth.
    assign w_in_range = ({1'b0, w_idx} < (IDXW+1)'(NB_WORDS));
    assign w_gnt      = tcdm.req & rst_ni & ~clear_i & (r_state == RSP_READY);
    assign w_clr      = ~rst_ni | clear_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_state <= RSP_READY;
            r_cnt   <= '0;
            r_id    <= '0;
            r_user  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_gnt & ~w_in_range;
            if (w_gnt) begin
                r_id   <= tcdm.id;
                r_user <= tcdm.user;
            end
            case (r_state)
                RSP_READY: begin
                    // ctrl_i is sampled only here, so mid-stall edits wait for the next grant.
                    if (w_gnt && ctrl_i.stall_en && ctrl_i.stall_cycles != 8'd0) begin
                        r_state <= RSP_STALL;
                        r_cnt   <= ctrl_i.stall_cycles;
                    end
                end
                default: begin
                    r_cnt <= r_cnt - 8'd1;
                    if (r_cnt == 8'd1) r_state <= RSP_READY;
                end
            endcase
        end
    end

    hci_mem_responder_storage #(
        .DW       (DW),
        .NB_WORDS (NB_WORDS),
        .IDXW     (IDXW)
    ) u_storage (
        .i_clk   (clk_i),
        .i_clr   (w_clr),
        .i_we    (w_gnt & ~tcdm.wen & w_in_range),
        .i_re    (w_gnt & tcdm.wen),
        .i_rzero (~w_in_range),
        .i_idx   (w_idx),
        .i_be    (tcdm.be),
        .i_wdata (tcdm.data),
        .o_rdata (w_rdata)
    );

    assign tcdm.gnt    = w_gnt;
    assign tcdm.r_data = w_rdata;
    assign tcdm.r_id   = r_id;
    assign tcdm.r_user = r_user;
    assign err_o       = r_err;
endmodule

// File: tb/tb_hci_mem_responder.sv
// Directed bench for hci_mem_responder built with a 1000-word (non-power-of-2) store.
module tb_hci_mem_responder;
    import hci_package::*;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    logic err;
    hci_responder_ctrl_t ctrl;
    int nchk = 0;
    int nerr = 0;

    hci_mem_intf #(.DW(32), .AW(32), .IW(8), .UW(1)) tcdm_if ();

    hci_mem_responder #(
        .DW(32), .AW(32), .IW(8), .UW(1), .NB_WORDS(1000)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clear_i (clear),
        .ctrl_i  (ctrl),
        .tcdm    (tcdm_if),
        .err_o   (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wen, input logic [31:0] add, input logic [31:0] data,
                         input logic [3:0] be, input logic [7:0] id);
        tcdm_if.req  = 1'b1;
        tcdm_if.wen  = wen;
        tcdm_if.add  = add;
        tcdm_if.data = data;
        tcdm_if.be   = be;
        tcdm_if.id   = id;
        tcdm_if.user = id[0];
    endtask

    task automatic idle();
        tcdm_if.req = 1'b0;
        tcdm_if.wen = 1'b1;
    endtask

    initial begin
        logic [0:7] p31;
        logic [0:9] p32;
        p31 = 8'b1000_1000;
        p32 = 10'b1001_0000_01;

        // Reset with req high: no grant, response registers zero.
        rst_n = 1'b0; clear = 1'b0; ctrl = '0;
        drive(1'b1, 32'h10, 32'h0, 4'hF, 8'hFF);
        tick();
        #1 check("gnt_in_reset", tcdm_if.gnt, 1'b0);
        check("rst_rdata", tcdm_if.r_data, 32'h0);
        check("rst_rid", tcdm_if.r_id, 8'h0);
        check("rst_ruser", tcdm_if.r_user, 1'b0);
        check("rst_err", err, 1'b0);
        rst_n = 1'b1; idle();
        #1 check("gnt_no_req", tcdm_if.gnt, 1'b0);
        tick();

        // Write then read back the same word.
        drive(1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 8'h11);
        #1 check("wr_gnt", tcdm_if.gnt, 1'b1);
        tick();
        check("wr_rid", tcdm_if.r_id, 8'h11);
        check("wr_ruser", tcdm_if.r_user, 1'b1);
        drive(1'b1, 32'h10, 32'h0, 4'hF, 8'h5A);
        #1 check("rd_gnt", tcdm_if.gnt, 1'b1);
        tick();
        check("rd_rdata", tcdm_if.r_data, 32'hDEADBEEF);
        check("rd_rid", tcdm_if.r_id, 8'h5A);
        check("rd_ruser", tcdm_if.r_user, 1'b0);

        // Read followed by write to the same word returns the old value, held.
        drive(1'b1, 32'h10, 32'h0, 4'hF, 8'h01);
        tick();
        drive(1'b0, 32'h10, 32'h12345678, 4'hF, 8'h02);
        #1 check("raw_old", tcdm_if.r_data, 32'hDEADBEEF);
        tick();
        check("raw_hold", tcdm_if.r_data, 32'hDEADBEEF);
        drive(1'b1, 32'h10, 32'h0, 4'hF, 8'h03);
        tick();
        check("raw_new", tcdm_if.r_data, 32'h12345678);

        // Partial byte-enable write.
        drive(1'b0, 32'h20, 32'h11223344, 4'hF, 8'h04);
        tick();
        drive(1'b0, 32'h20, 32'hAABBCCDD, 4'b0101, 8'h05);
        tick();
        drive(1'b1, 32'h20, 32'h0, 4'hF, 8'h06);
        tick();
        check("be_merge", tcdm_if.r_data, 32'h11BB33DD);

        // Stall of 3 cycles with req held.
        ctrl.stall_en = 1'b1; ctrl.stall_cycles = 8'd3;
        drive(1'b1, 32'h10, 32'h0, 4'hF, 8'h07);
        for (int i = 0; i < 8; i++) begin
            #1 check($sformatf("stall3_gnt%0d", i), tcdm_if.gnt, p31[i]);
            tick();
        end

        // Stall length sampled at acceptance only: 2 then 5.
        ctrl.stall_cycles = 8'd2;
        for (int i = 0; i < 10; i++) begin
            if (i == 1) ctrl.stall_cycles = 8'd5;
            if (i == 9) ctrl.stall_en = 1'b0;
            #1 check($sformatf("resample_gnt%0d", i), tcdm_if.gnt, p32[i]);
            tick();
        end

        // stall_cycles=0 with stall enabled grants every cycle.
        ctrl.stall_en = 1'b1; ctrl.stall_cycles = 8'd0;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("zero_stall_gnt%0d", i), tcdm_if.gnt, 1'b1);
            tick();
        end
        ctrl = '0;

        // Out-of-range accesses around the last legal word.
        drive(1'b0, 32'd3996, 32'h99999999, 4'hF, 8'h08);
        tick();
        drive(1'b0, 32'd4000, 32'hCAFEF00D, 4'hF, 8'h33);
        tick();
        check("oor_wr_err", err, 1'b1);
        check("oor_wr_rid", tcdm_if.r_id, 8'h33);
        idle();
        tick();
        check("oor_err_clear", err, 1'b0);
        drive(1'b1, 32'h10, 32'h0, 4'hF, 8'h09);
        tick();
        check("pre_oor_rd", tcdm_if.r_data, 32'h12345678);
        drive(1'b1, 32'd4000, 32'h0, 4'hF, 8'h77);
        tick();
        check("oor_rd_rdata", tcdm_if.r_data, 32'h0);
        check("oor_rd_err", err, 1'b1);
        check("oor_rd_rid", tcdm_if.r_id, 8'h77);
        drive(1'b1, 32'd3996, 32'h0, 4'hF, 8'h0A);
        tick();
        check("oor_err_pulse", err, 1'b0);
        check("last_word", tcdm_if.r_data, 32'h99999999);

        // Soft clear mid-stall.
        ctrl.stall_en = 1'b1; ctrl.stall_cycles = 8'd4;
        drive(1'b1, 32'h20, 32'h0, 4'hF, 8'h44);
        #1 check("clr_first_gnt", tcdm_if.gnt, 1'b1);
        tick();
        check("clr_pre_rdata", tcdm_if.r_data, 32'h11BB33DD);
        #1 check("clr_stall_gnt", tcdm_if.gnt, 1'b0);
        tick();
        clear = 1'b1;
        #1 check("clr_gnt", tcdm_if.gnt, 1'b0);
        tick();
        clear = 1'b0; ctrl = '0;
        drive(1'b1, 32'h10, 32'h0, 4'hF, 8'h45);
        #1 check("post_clr_gnt", tcdm_if.gnt, 1'b1);
        check("post_clr_rdata", tcdm_if.r_data, 32'h0);
        check("post_clr_rid", tcdm_if.r_id, 8'h0);
        tick();
        check("post_clr_w10", tcdm_if.r_data, 32'h12345678);
        drive(1'b1, 32'h20, 32'h0, 4'hF, 8'h46);
        tick();
        check("post_clr_w20", tcdm_if.r_data, 32'h11BB33DD);

        // Reset aborts a stall in progress.
        ctrl.stall_en = 1'b1; ctrl.stall_cycles = 8'd5;
        drive(1'b1, 32'h10, 32'h0, 4'hF, 8'h47);
        tick();
        #1 check("rst_stall_gnt", tcdm_if.gnt, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; ctrl = '0;
        #1 check("post_rst_gnt", tcdm_if.gnt, 1'b1);
        check("post_rst_rdata", tcdm_if.r_data, 32'h0);
        tick();
        check("post_rst_w10", tcdm_if.r_data, 32'h12345678);
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
